// File: rtl/rf_ctrl_pkg.sv
// Shared constants and FSM encoding for the register-file controller.
package rf_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] LAST_REG = 5'd31;

  typedef enum logic {ST_INIT, ST_RUN} state_e;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register in-flight write counters, hazard stall compare and sticky error.
module rf_scoreboard
  import rf_ctrl_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_en,
  input  logic [REG_ADDR_W-1:0] inc_rd,
  input  logic                  dec_en,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic                  use1,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic                  use2,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic                  raw_stall,
  output logic                  dbg_free,
  output logic                  sb_err
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

  // Entry 0 is held at zero so address 0 never reports a pending write.
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_REGS-1:0]            inc_hit, dec_hit;
  logic                           sb_err_q, sb_err_d;

  always_comb begin
    inc_hit  = inc_en ? (ONE << inc_rd) : '0;
    dec_hit  = dec_en ? (ONE << dec_rd) : '0;
    cnt_d    = cnt_q;
    sb_err_d = sb_err_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (inc_hit[i] && !dec_hit[i])
        cnt_d[i] = cnt_q[i] + 1'b1;
      else if (dec_hit[i] && !inc_hit[i] && cnt_q[i] != '0)
        cnt_d[i] = cnt_q[i] - 1'b1;
    end
    cnt_d[0] = '0;
    // A writeback nobody was waiting for is a scoreboard underflow.
    if (dec_en && dec_rd != '0 && cnt_q[dec_rd] == '0)
      sb_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      sb_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign raw_stall = (use1 && rs1 != '0 && cnt_q[rs1] != '0) ||
                     (use2 && rs2 != '0 && cnt_q[rs2] != '0) ||
                     (we   && rd  != '0 && cnt_q[rd]  == CNT_MAX);
  assign dbg_free  = (cnt_q[dbg_addr] == '0);
  assign sb_err    = sb_err_q;
endmodule

// File: rtl/rf_ctrl.sv
// Register-file controller: post-reset clear, issue scoreboarding and
// write-port arbitration between clear, writeback and debug.
module rf_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  issue_valid,
  input  logic                  issue_we,
  input  logic [4:0]            issue_rd,
  input  logic [4:0]            issue_rs1,
  input  logic [4:0]            issue_rs2,
  input  logic                  issue_use1,
  input  logic                  issue_use2,
  output logic                  issue_stall,
  input  logic                  wb_valid,
  input  logic [4:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  dbg_req,
  input  logic [4:0]            dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_data,
  output logic                  dbg_ack,
  output logic                  write,
  output logic [4:0]            dest_add,
  output logic [DATA_WIDTH-1:0] dest_data,
  output logic                  init_done,
  output logic                  sb_err
);
  state_e                  state_q, state_d;
  logic [REG_ADDR_W-1:0]   clr_q, clr_d;
  logic                    dbg_ack_q, dbg_ack_d;
  logic                    run, raw_stall, dbg_free, dbg_grant, inc_en, dec_en;

  assign run         = (state_q == ST_RUN);
  assign issue_stall = !run || raw_stall;
  assign inc_en      = run && issue_valid && !issue_stall && issue_we && issue_rd != '0;
  assign dec_en      = run && wb_valid && wb_rd != '0;
  // No re-grant while the previous ack is on the wire: dbg_req is still held then.
  assign dbg_grant   = run && dbg_req && !wb_valid && dbg_free && !dbg_ack_q;

  rf_scoreboard #(.CNT_W(CNT_W)) u_sb (
    .clk      (Clk),
    .rst_n    (Rst),
    .inc_en   (inc_en),
    .inc_rd   (issue_rd),
    .dec_en   (dec_en),
    .dec_rd   (wb_rd),
    .use1     (issue_use1),
    .rs1      (issue_rs1),
    .use2     (issue_use2),
    .rs2      (issue_rs2),
    .we       (issue_we),
    .rd       (issue_rd),
    .dbg_addr (dbg_addr),
    .raw_stall(raw_stall),
    .dbg_free (dbg_free),
    .sb_err   (sb_err)
  );

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    dbg_ack_d = dbg_grant;
    if (state_q == ST_INIT) begin
      clr_d = clr_q + 5'd1;
      if (clr_q == LAST_REG - 5'd1) begin
        state_d = ST_RUN;
        clr_d   = '0;
      end
    end
  end

  always_comb begin
    write     = 1'b0;
    dest_add  = '0;
    dest_data = '0;
    if (!run) begin
      write    = 1'b1;
      dest_add = clr_q + 5'd1;
    end else if (wb_valid && wb_rd != '0) begin
      write     = 1'b1;
      dest_add  = wb_rd;
      dest_data = wb_data;
    end else if (dbg_grant && dbg_addr != '0) begin
      write     = 1'b1;
      dest_add  = dbg_addr;
      dest_data = dbg_data;
    end
    if (!Rst)
      write = 1'b0;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= ST_INIT;
      clr_q     <= '0;
      dbg_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_q     <= clr_d;
      dbg_ack_q <= dbg_ack_d;
    end
  end

  assign dbg_ack   = dbg_ack_q;
  assign init_done = run;
endmodule

// File: tb/tb_rf_ctrl.sv
// Directed + randomized bench for rf_ctrl against an array-based reference model.
module tb_rf_ctrl;
  localparam int MAXC = 3;

  logic        Clk = 1'b0, Rst = 1'b0;
  logic        issue_valid, issue_we, issue_use1, issue_use2;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        dbg_req, dbg_ack;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        write, init_done, sb_err;
  logic [4:0]  dest_add;
  logic [31:0] dest_data;

  int checks = 0, failures = 0;

  // reference model state
  int m_cnt[32];
  bit m_run, m_sberr, m_ack;
  int m_idx;

  rf_ctrl #(.DATA_WIDTH(32), .CNT_W(2)) dut (
    .Clk(Clk), .Rst(Rst),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_use1(issue_use1),
    .issue_use2(issue_use2), .issue_stall(issue_stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_ack(dbg_ack),
    .write(write), .dest_add(dest_add), .dest_data(dest_data),
    .init_done(init_done), .sb_err(sb_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0; issue_we = 0; issue_use1 = 0; issue_use2 = 0;
    issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic model_clear();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_run = 0; m_sberr = 0; m_ack = 0; m_idx = 1;
  endtask

  // Inputs are already applied (posedge+1); check mid-cycle, then advance.
  task automatic cycle();
    bit stall_e, grant_e, wr_e, inc, dec;
    logic [4:0]  add_e;
    logic [31:0] data_e;
    #3;
    stall_e = !m_run ||
              (issue_use1 && issue_rs1 != 0 && m_cnt[issue_rs1] != 0) ||
              (issue_use2 && issue_rs2 != 0 && m_cnt[issue_rs2] != 0) ||
              (issue_we && issue_rd != 0 && m_cnt[issue_rd] == MAXC);
    grant_e = m_run && dbg_req && !wb_valid && m_cnt[dbg_addr] == 0 && !m_ack;
    wr_e = 0; add_e = 0; data_e = 0;
    if (!m_run) begin wr_e = 1; add_e = 5'(m_idx); end
    else if (wb_valid && wb_rd != 0) begin wr_e = 1; add_e = wb_rd; data_e = wb_data; end
    else if (grant_e && dbg_addr != 0) begin wr_e = 1; add_e = dbg_addr; data_e = dbg_data; end
    chk("issue_stall", issue_stall, stall_e);
    chk("write", write, wr_e);
    if (wr_e) begin
      chk("dest_add", dest_add, add_e);
      chk("dest_data", dest_data, data_e);
    end
    chk("dbg_ack", dbg_ack, m_ack);
    chk("init_done", init_done, m_run);
    chk("sb_err", sb_err, m_sberr);
    @(posedge Clk);
    if (!m_run) begin
      if (m_idx == 31) m_run = 1; else m_idx++;
      m_ack = 0;
    end else begin
      inc = issue_valid && !stall_e && issue_we && issue_rd != 0;
      dec = wb_valid && wb_rd != 0;
      if (dec && m_cnt[wb_rd] == 0) m_sberr = 1;
      if (!(inc && dec && issue_rd == wb_rd)) begin
        if (inc) m_cnt[issue_rd]++;
        if (dec && m_cnt[wb_rd] > 0) m_cnt[wb_rd]--;
      end
      m_ack = grant_e;
    end
    #1;
  endtask

  task automatic assert_reset(input string tag);
    Rst = 0;
    #1;
    model_clear();
    chk({tag, "_write"}, write, 1'b0);
    chk({tag, "_init_done"}, init_done, 1'b0);
    chk({tag, "_sb_err"}, sb_err, 1'b0);
    chk({tag, "_dbg_ack"}, dbg_ack, 1'b0);
    chk({tag, "_stall"}, issue_stall, 1'b1);
  endtask

  task automatic release_reset();
    @(posedge Clk); @(posedge Clk); #1;
    Rst = 1;
  endtask

  initial begin
    bit ack_prev;
    idle(); dbg_req = 0; dbg_addr = 0; dbg_data = 0;
    #2;
    assert_reset("rst0");
    release_reset();

    // clear sequence; traffic during it must be ignored
    for (int i = 0; i < 31; i++) begin
      issue_valid = (i % 3 == 0); issue_we = 1; issue_rd = 5'd5;
      wb_valid = (i % 4 == 1); wb_rd = 5'd4; wb_data = 32'h1234;
      cycle();
    end
    idle();
    chk("run_init_done", init_done, 1'b1);
    chk("run_stall", issue_stall, 1'b0);

    // RAW on r5, released the cycle after its writeback
    issue_valid = 1; issue_we = 1; issue_rd = 5; cycle();
    issue_we = 0; issue_rd = 0; issue_use1 = 1; issue_rs1 = 5;
    cycle(); cycle();
    wb_valid = 1; wb_rd = 5; wb_data = 32'h0A0A_0505; cycle();
    wb_valid = 0;
    chk("raw_release", issue_stall, 1'b0);
    cycle();
    idle();

    // counter saturation on r7
    issue_valid = 1; issue_we = 1; issue_rd = 7;
    cycle(); cycle(); cycle();
    chk("sat_stall", issue_stall, 1'b1);
    cycle();
    wb_valid = 1; wb_rd = 7; wb_data = 32'h77; cycle();
    wb_valid = 0; cycle();
    idle();

    // debug write loses to writeback, then writes, then acks
    issue_valid = 1; issue_we = 1; issue_rd = 3; cycle();
    idle();
    dbg_req = 1; dbg_addr = 9; dbg_data = 32'hDEADBEEF;
    wb_valid = 1; wb_rd = 3; wb_data = 32'h33; cycle();
    wb_valid = 0; cycle();
    chk("dbg_ack_pulse", dbg_ack, 1'b1);
    cycle();
    dbg_req = 0; cycle();

    // debug to r0 acks without writing
    dbg_req = 1; dbg_addr = 0; dbg_data = 32'hFFFF_FFFF; cycle(); cycle();
    dbg_req = 0; cycle();

    // underflow writeback sets sticky error
    wb_valid = 1; wb_rd = 12; wb_data = 32'hC0C0; cycle();
    wb_valid = 0; cycle(); cycle();
    chk("sb_err_sticky", sb_err, 1'b1);

    // randomized traffic
    ack_prev = 0;
    for (int n = 0; n < 400; n++) begin
      int r;
      issue_valid = $urandom_range(0, 1);
      issue_we = $urandom_range(0, 1);
      issue_use1 = $urandom_range(0, 1);
      issue_use2 = $urandom_range(0, 1);
      issue_rd = 5'($urandom_range(0, 7));
      issue_rs1 = 5'($urandom_range(0, 7));
      issue_rs2 = 5'($urandom_range(0, 7));
      r = $urandom_range(0, 7);
      wb_valid = $urandom_range(0, 2) != 0 && (m_cnt[r] > 0 || $urandom_range(0, 15) == 0);
      wb_rd = 5'(r);
      wb_data = $urandom;
      if (dbg_req && ack_prev) dbg_req = 0;
      else if (!dbg_req && $urandom_range(0, 3) == 0) begin
        dbg_req = 1; dbg_addr = 5'($urandom_range(0, 7)); dbg_data = $urandom;
      end
      ack_prev = m_ack;
      cycle();
    end
    idle(); dbg_req = 0;
    cycle();

    // reset in the middle of the clear sequence restarts it from r1
    assert_reset("rst1");
    release_reset();
    for (int i = 0; i < 10; i++) cycle();
    assert_reset("rst2");
    release_reset();
    chk("restart_add", dest_add, 5'd1);
    for (int i = 0; i < 33; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
